// File: rtl/pc_bpu.sv
// Fetch PC register with an optional direct-mapped BTB / 2-bit counter predictor.
// Define PC_BPU_PRED_EN to build the BTB; otherwise fetch always predicts PC+4.
module pc_bpu #(
  parameter int                ADDR_W    = 32,
  parameter int                BTB_DEPTH = 16,
  parameter int                STALL_W   = 6,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic [STALL_W-1:0] stall,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               upd_en,
  input  logic [ADDR_W-1:0]  upd_pc,
  input  logic               upd_taken,
  input  logic [ADDR_W-1:0]  upd_target,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               pred_taken_o,
  output logic [ADDR_W-1:0]  pred_pc_o
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] seq_pc;

  assign seq_pc = pc_q + ADDR_W'(4);
  assign pc_o   = pc_q;

`ifdef PC_BPU_PRED_EN
  logic              vld_q [BTB_DEPTH];
  logic [1:0]        cnt_q [BTB_DEPTH];
  logic [TAG_W-1:0]  tag_q [BTB_DEPTH];
  logic [ADDR_W-1:0] tgt_q [BTB_DEPTH];

  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [TAG_W-1:0]  rd_tag, wr_tag;
  logic              rd_hit, upd_hit;
  logic              upd_we, tgt_we;
  logic [1:0]        cnt_d;
  logic              unused_upd_lsb;

  assign rd_idx = pc_q[IDX_W+1:2];
  assign rd_tag = pc_q[ADDR_W-1:IDX_W+2];
  assign rd_hit = vld_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

  assign pred_taken_o = rd_hit & cnt_q[rd_idx][1];
  assign pred_pc_o    = pred_taken_o ? tgt_q[rd_idx] : seq_pc;

  assign wr_idx         = upd_pc[IDX_W+1:2];
  assign wr_tag         = upd_pc[ADDR_W-1:IDX_W+2];
  assign upd_hit        = vld_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign unused_upd_lsb = ^upd_pc[1:0];

  // A not-taken miss writes nothing; a taken miss allocates weakly-taken.
  assign upd_we = rdy & upd_en & (upd_hit | upd_taken);
  assign tgt_we = upd_we & upd_taken;

  always_comb begin
    cnt_d = 2'b10;
    if (upd_hit) begin
      cnt_d = cnt_q[wr_idx];
      if (upd_taken && cnt_q[wr_idx] != 2'b11)
        cnt_d = cnt_q[wr_idx] + 2'd1;
      else if (!upd_taken && cnt_q[wr_idx] != 2'b00)
        cnt_d = cnt_q[wr_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        vld_q[i] <= 1'b0;
        cnt_q[i] <= 2'b01;
      end
    end else if (upd_we) begin
      vld_q[wr_idx] <= 1'b1;
      cnt_q[wr_idx] <= cnt_d;
    end
  end

  // Tags and targets are qualified by the valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    if (upd_we)
      tag_q[wr_idx] <= wr_tag;
    if (tgt_we)
      tgt_q[wr_idx] <= upd_target;
  end
`else
  logic unused_upd;

  assign unused_upd   = ^{upd_en, upd_pc, upd_taken, upd_target};
  assign pred_taken_o = 1'b0;
  assign pred_pc_o    = seq_pc;
`endif

  // Redirect beats stall; an unstalled fetch follows the prediction.
  always_comb begin
    pc_d = pc_q;
    if (redirect_en)
      pc_d = redirect_pc;
    else if (stall == '0)
      pc_d = pred_pc_o;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pc_q <= RESET_PC;
    else if (rdy)
      pc_q <= pc_d;
  end

endmodule

// File: tb/tb_pc_bpu.sv
// Scoreboard bench for pc_bpu: directed scenarios plus random traffic against a BTB reference model.
module tb_pc_bpu;

`ifdef PC_BPU_PRED_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [5:0]  stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] pc_o;
  logic        pred_taken_o;
  logic [31:0] pred_pc_o;

  always #5 clk = ~clk;

  pc_bpu dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .pc_o(pc_o), .pred_taken_o(pred_taken_o), .pred_pc_o(pred_pc_o)
  );

  typedef struct { logic [31:0] pc; logic tk; logic [31:0] ppc; } exp_t;
  typedef struct { string nm; logic [31:0] act; logic [31:0] exp; } dchk_t;

  exp_t  exp_q[$];
  dchk_t dchk_q[$];
  int    npass = 0;
  int    ntot  = 0;

  // Reference model: the BTB as a table of entries keyed by word index.
  logic [31:0] m_pc;
  bit          mv   [DEPTH];
  logic [31:0] mtag [DEPTH];
  logic [31:0] mtgt [DEPTH];
  int          mcnt [DEPTH];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("pc_o", pc_o, e.pc);
      cmp("pred_taken_o", {31'd0, pred_taken_o}, {31'd0, e.tk});
      cmp("pred_pc_o", pred_pc_o, e.ppc);
    end
    while (dchk_q.size() != 0) begin
      dchk_t d;
      d = dchk_q.pop_front();
      cmp(d.nm, d.act, d.exp);
    end
  end

  task automatic dchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    dchk_t d;
    d.nm = nm; d.act = act; d.exp = exp;
    dchk_q.push_back(d);
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      mv[i] = 1'b0;
      mcnt[i] = 1;
    end
  endtask

  task automatic model_pred(output logic tk, output logic [31:0] np);
    int idx;
    idx = int'((m_pc / 4) % DEPTH);
    tk  = PRED && mv[idx] && (mtag[idx] == m_pc / (4 * DEPTH)) && (mcnt[idx] >= 2);
    np  = tk ? mtgt[idx] : m_pc + 32'd4;
  endtask

  task automatic model_upd(input logic [31:0] a, input logic t, input logic [31:0] tg);
    int idx;
    if (!PRED) return;
    idx = int'((a / 4) % DEPTH);
    if (mv[idx] && mtag[idx] == a / (4 * DEPTH)) begin
      mcnt[idx] = t ? ((mcnt[idx] < 3) ? mcnt[idx] + 1 : 3) : ((mcnt[idx] > 0) ? mcnt[idx] - 1 : 0);
      if (t) mtgt[idx] = tg;
    end else if (t) begin
      mv[idx] = 1'b1; mtag[idx] = a / (4 * DEPTH); mtgt[idx] = tg; mcnt[idx] = 2;
    end
  endtask

  task automatic cycle(input logic r, input logic [5:0] s, input logic re, input logic [31:0] rp,
                       input logic ue, input logic [31:0] up, input logic ut, input logic [31:0] utg);
    exp_t e;
    logic tk;
    logic [31:0] np;
    model_pred(tk, np);
    e.pc = m_pc; e.tk = tk; e.ppc = np;
    exp_q.push_back(e);
    rdy = r; stall = s; redirect_en = re; redirect_pc = rp;
    upd_en = ue; upd_pc = up; upd_taken = ut; upd_target = utg;
    @(posedge clk);
    if (r) begin
      if (ue) model_upd(up, ut, utg);
      if (re) m_pc = rp;
      else if (s == 6'd0) m_pc = np;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic upd_hold(input logic [31:0] a, input logic t, input logic [31:0] tg);
    cycle(1'b1, 6'd1, 1'b0, 32'h0, 1'b1, a, t, tg);
  endtask

  task automatic go(input logic [31:0] a);
    cycle(1'b1, 6'd1, 1'b1, a, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      logic r, re, ue, ut;
      logic [5:0] s;
      logic [31:0] rp, up, utg;
      r   = ($urandom_range(0, 9) != 0);
      s   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      re  = ($urandom_range(0, 7) == 0);
      rp  = 32'($urandom_range(0, 1023));
      ue  = ($urandom_range(0, 1) == 1);
      up  = ($urandom_range(0, 2) == 0) ? m_pc : 32'($urandom_range(0, 1023));
      ut  = ($urandom_range(0, 2) != 0);
      utg = 32'($urandom_range(0, 1023));
      cycle(r, s, re, rp, ue, up, ut, utg);
    end
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; stall = 6'd0; redirect_en = 1'b0; redirect_pc = 32'h0;
    upd_en = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;
    #3;
    dchk("reset_pc", pc_o, 32'h0);
    dchk("reset_pred", {31'd0, pred_taken_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();

    // Sequential fetch from reset
    idle(3);
    dchk("seq_pc_c", pc_o, 32'hC);

    // Redirect overrides stall, then stall holds
    cycle(1'b1, 6'd1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 6'd1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 6'd1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    dchk("stall_hold", pc_o, 32'h100);

    // Allocate 0x40 -> 0x200 and fetch it
    upd_hold(32'h40, 1'b1, 32'h200);
    go(32'h40);
    dchk("alloc_pred", {31'd0, pred_taken_o}, {31'd0, PRED});
    idle(1);
    dchk("alloc_next", pc_o, PRED ? 32'h200 : 32'h44);
    upd_hold(32'h40, 1'b0, 32'h0);
    upd_hold(32'h40, 1'b0, 32'h0);
    go(32'h40);
    dchk("nt_pred", {31'd0, pred_taken_o}, 32'd0);
    idle(1);
    dchk("nt_next", pc_o, 32'h44);

    // Aliasing tags on index 0
    upd_hold(32'h40, 1'b1, 32'h200);
    upd_hold(32'h80, 1'b1, 32'h300);
    go(32'h40);
    dchk("alias_40", pred_pc_o, 32'h44);
    go(32'h80);
    dchk("alias_80", pred_pc_o, PRED ? 32'h300 : 32'h84);
    idle(2);

    // Counter saturation, then rdy=0 freeze
    for (int i = 0; i < 4; i++) upd_hold(32'h40, 1'b1, 32'h200);
    upd_hold(32'h40, 1'b0, 32'h0);
    go(32'h40);
    dchk("sat_pred", {31'd0, pred_taken_o}, {31'd0, PRED});
    for (int i = 0; i < 5; i++) cycle(1'b0, 6'd0, 1'b1, 32'h500, 1'b1, 32'h40, 1'b0, 32'h0);
    dchk("frz_pc", pc_o, 32'h40);
    dchk("frz_pred", pred_pc_o, PRED ? 32'h200 : 32'h44);
    idle(2);

    rand_cycles(1500);

    // Asynchronous reset mid-run with a pending redirect and update
    rst = 1'b0;
    #1 dchk("async_rst_pc", pc_o, 32'h0);
    dchk("async_rst_pred", {31'd0, pred_taken_o}, 32'd0);
    redirect_en = 1'b1; redirect_pc = 32'h999; upd_en = 1'b1; upd_pc = 32'h0; upd_taken = 1'b1;
    repeat (2) @(posedge clk);
    #1 dchk("rst_hold_pc", pc_o, 32'h0);
    dchk("rst_btb_clear", pred_pc_o, 32'h4);
    redirect_en = 1'b0; upd_en = 1'b0;
    rst = 1'b1;
    model_reset();
    idle(2);
    rand_cycles(500);

    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
